addaccu_n: RTL and testbench

ADDACCU_N -- requirements
Module: addaccu_n

---
 rtl/addaccu_pkg.sv | 10 +
 rtl/addaccu_n_if.sv | 33 +++
 rtl/addaccu_n_addsub_sat.sv | 23 ++
 rtl/addaccu_n.sv | 99 +++++++++
 tb/tb_addaccu_n.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/addaccu_pkg.sv
// Shared types for the block accumulator: FSM state encoding.
package addaccu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : addaccu_pkg

// File: rtl/addaccu_n_if.sv
// Sample-in / result-out handshake bundle for addaccu_n.
interface addaccu_n_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 8
) ();
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sel;
   logic             sub;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             ovf;
   logic [CW-1:0]    count;

   // Producer/consumer side (drives samples, takes results)
   modport master (
      output in_valid, a, b, sel, sub, in_last, out_ready,
      input  in_ready, out_valid, sum, carry, ovf, count
   );

   // Accumulator side
   modport slave (
      input  in_valid, a, b, sel, sub, in_last, out_ready,
      output in_ready, out_valid, sum, carry, ovf, count
   );
endinterface : addaccu_n_if

// File: rtl/addaccu_n_addsub_sat.sv
// Combinational add/subtract with carry/borrow out and optional clamping.
module addsub_sat #(
   parameter int unsigned WIDTH    = 4,
   parameter bit          SATURATE = 1'b0
) (
   input  logic [WIDTH-1:0] op,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] res_c,
   output logic             carry_c
);
   logic [WIDTH:0] full_c;

   // Widened add/sub; top bit is carry-out (add) or borrow (sub)
   always_comb begin
      full_c  = sub ? ({1'b0, op} - {1'b0, b}) : ({1'b0, op} + {1'b0, b});
      carry_c = full_c[WIDTH];
      res_c   = full_c[WIDTH-1:0];
      if (SATURATE && carry_c) begin
         res_c = sub ? '0 : '1;
      end
   end
endmodule : addsub_sat

// File: rtl/addaccu_n.sv
// Block accumulator: folds up to DEPTH samples, then holds the result until taken.
module addaccu_n
   import addaccu_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned DEPTH    = 8,
   parameter bit          SATURATE = 1'b0
) (
   input  logic       ck,
   input  logic       rst,
   addaccu_n_if.slave bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic             ovf;
   logic [CW-1:0]    count;
   logic             in_ready;
   logic             out_valid;

   logic [WIDTH-1:0] operand;
   logic [WIDTH-1:0] res_c;
   logic             carry_c;
   logic [CW-1:0]    count_inc;
   logic             accept;
   logic             block_end;

   assign operand   = bus.sel ? acc : bus.a;
   assign accept    = bus.in_valid && in_ready;
   assign count_inc = count + CW'(1);
   assign block_end = (count_inc == CW'(DEPTH)) || bus.in_last;

   addsub_sat #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
   ) u_addsub (
      .op      (operand),
      .b       (bus.b),
      .sub     (bus.sub),
      .res_c   (res_c),
      .carry_c (carry_c)
   );

   // Block FSM with registered datapath and handshake outputs
   always_ff @(posedge ck) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         carry     <= 1'b0;
         ovf       <= 1'b0;
         count     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (accept) begin
                  acc   <= res_c;
                  carry <= carry_c;
                  ovf   <= ovf | carry_c;
                  count <= count_inc;
                  if (block_end) begin
                     state     <= DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state     <= IDLE;
                  acc       <= '0;
                  carry     <= 1'b0;
                  ovf       <= 1'b0;
                  count     <= '0;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sum       = acc;
   assign bus.carry     = carry;
   assign bus.ovf       = ovf;
   assign bus.count     = count;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
endmodule : addaccu_n

// File: tb/tb_addaccu_n.sv
// Directed bench: wrap and saturating accumulators driven in lockstep.
module tb_addaccu_n;
   localparam int unsigned W = 4;
   localparam int unsigned D = 4;

   logic ck;
   logic rst;
   int   checks;
   int   errors;

   addaccu_n_if #(.WIDTH(W), .DEPTH(D)) bw ();
   addaccu_n_if #(.WIDTH(W), .DEPTH(D)) bs ();

   addaccu_n #(.WIDTH(W), .DEPTH(D), .SATURATE(1'b0)) dut_w (
      .ck  (ck),
      .rst (rst),
      .bus (bw.slave)
   );

   addaccu_n #(.WIDTH(W), .DEPTH(D), .SATURATE(1'b1)) dut_s (
      .ck  (ck),
      .rst (rst),
      .bus (bs.slave)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Same sample to both instances
   task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sel, input logic sub, input logic last);
      bw.in_valid = v; bw.a = a; bw.b = b; bw.sel = sel; bw.sub = sub; bw.in_last = last;
      bs.in_valid = v; bs.a = a; bs.b = b; bs.sel = sel; bs.sub = sub; bs.in_last = last;
   endtask

   task automatic set_oready(input logic r);
      bw.out_ready = r;
      bs.out_ready = r;
   endtask

   task automatic step();
      @(posedge ck);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_sum_w"},   32'(bw.sum), 0);
      chk({tag, "_carry_w"}, 32'(bw.carry), 0);
      chk({tag, "_ovf_w"},   32'(bw.ovf), 0);
      chk({tag, "_count_w"}, 32'(bw.count), 0);
      chk({tag, "_ov_w"},    32'(bw.out_valid), 0);
      chk({tag, "_ir_w"},    32'(bw.in_ready), 1);
      chk({tag, "_sum_s"},   32'(bs.sum), 0);
      chk({tag, "_count_s"}, 32'(bs.count), 0);
      chk({tag, "_ir_s"},    32'(bs.in_ready), 1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      set_oready(1'b0);

      // Reset held two cycles
      step();
      step();
      rst = 1'b0;
      chk_idle("reset");

      // Basic block of DEPTH samples
      drive(1'b1, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0);
      step();
      chk("blk_s1_sum", 32'(bw.sum), 8);
      chk("blk_s1_cnt", 32'(bw.count), 1);
      drive(1'b1, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0);
      step();
      chk("blk_s2_sum", 32'(bw.sum), 10);
      drive(1'b1, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
      step();
      chk("blk_s3_sum", 32'(bw.sum), 11);
      chk("blk_s3_ov", 32'(bw.out_valid), 0);
      drive(1'b1, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0);
      step();
      chk("blk_s4_sum_w", 32'(bw.sum), 15);
      chk("blk_s4_sum_s", 32'(bs.sum), 15);
      chk("blk_ov", 32'(bw.out_valid), 1);
      chk("blk_ovf", 32'(bw.ovf), 0);
      chk("blk_cnt", 32'(bw.count), 4);
      chk("blk_ir", 32'(bw.in_ready), 0);

      // Backpressure: DONE holds while samples keep being offered
      drive(1'b1, 4'd7, 4'd7, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_sum", 32'(bw.sum), 15);
         chk("bp_cnt", 32'(bw.count), 4);
         chk("bp_ir", 32'(bw.in_ready), 0);
         chk("bp_ov", 32'(bw.out_valid), 1);
      end
      set_oready(1'b1);
      step();
      set_oready(1'b0);
      chk_idle("drain1");

      // Overflow: 9+8 wraps to 1 or clamps to 15; sticky ovf to block end
      drive(1'b1, 4'd9, 4'd8, 1'b0, 1'b0, 1'b0);
      step();
      chk("ovf_sum_w", 32'(bw.sum), 1);
      chk("ovf_carry_w", 32'(bw.carry), 1);
      chk("ovf_ovf_w", 32'(bw.ovf), 1);
      chk("ovf_sum_s", 32'(bs.sum), 15);
      chk("ovf_carry_s", 32'(bs.carry), 1);
      chk("ovf_ovf_s", 32'(bs.ovf), 1);
      drive(1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      step();
      chk("ovf2_sum_w", 32'(bw.sum), 1);
      chk("ovf2_carry_w", 32'(bw.carry), 0);
      chk("ovf2_ovf_w", 32'(bw.ovf), 1);
      chk("ovf2_sum_s", 32'(bs.sum), 15);
      drive(1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1);
      step();
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      chk("ovf3_ov", 32'(bw.out_valid), 1);
      chk("ovf3_cnt", 32'(bw.count), 3);
      chk("ovf3_ovf_w", 32'(bw.ovf), 1);
      chk("ovf3_ovf_s", 32'(bs.ovf), 1);
      set_oready(1'b1);
      step();
      set_oready(1'b0);
      chk_idle("drain2");

      // Borrow: 2-5 wraps to 13 or clamps to 0; in_last on 2nd sample
      drive(1'b1, 4'd2, 4'd5, 1'b0, 1'b1, 1'b0);
      step();
      chk("brw_sum_w", 32'(bw.sum), 13);
      chk("brw_carry_w", 32'(bw.carry), 1);
      chk("brw_sum_s", 32'(bs.sum), 0);
      chk("brw_carry_s", 32'(bs.carry), 1);
      drive(1'b1, 4'd0, 4'd1, 1'b1, 1'b0, 1'b1);
      step();
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      chk("last_sum_w", 32'(bw.sum), 14);
      chk("last_sum_s", 32'(bs.sum), 1);
      chk("last_cnt", 32'(bw.count), 2);
      chk("last_ov", 32'(bw.out_valid), 1);
      chk("last_ovf", 32'(bw.ovf), 1);
      chk("last_carry", 32'(bw.carry), 0);
      set_oready(1'b1);
      step();
      set_oready(1'b0);
      chk_idle("drain3");

      // Reset mid-ACCUM wins over an offered sample
      drive(1'b1, 4'd15, 4'd1, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
      step();
      chk("mid_sum", 32'(bw.sum), 1);
      chk("mid_cnt", 32'(bw.count), 2);
      chk("mid_ovf", 32'(bw.ovf), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      chk_idle("midrst");

      // sel=1 from IDLE starts from zero
      drive(1'b1, 4'd9, 4'd6, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      chk("sel1_sum", 32'(bw.sum), 6);
      chk("sel1_cnt", 32'(bw.count), 1);

      // Reset during DONE
      drive(1'b1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b1);
      step();
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      chk("done_ov", 32'(bw.out_valid), 1);
      chk("done_sum", 32'(bw.sum), 2);
      rst = 1'b1;
      set_oready(1'b1);
      step();
      rst = 1'b0;
      set_oready(1'b0);
      chk_idle("donerst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule : tb_addaccu_n
